serial_pattern_tx: RTL and testbench
====================================

Name: serial_pattern_tx

Overview:
- Serial bit-pattern transmitter; the generator side of the serial sequence-detector family (mealy10010 and its variants).
- Shifts a WIDTH-bit pattern out MSB-first on a single line j, one bit per clock, as single frames or continuous repeats.
- Drives detector benches and loopback checks, replacing hand-timed stimulus with cycle-exact frames.

Parameters:
- WIDTH, 5, pattern length in bits (2..16).
- PATTERN, 5'b10010, pattern loaded at reset.
- GAP, 2, number of IDLE_BIT cycles inserted between repeated frames (0..15).
- IDLE_BIT, 1'b0, level on j when not sending.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  reset; synchronous, active-low; all state is sampled on the clk edge.
- start  input  1  begin a frame; sampled only in IDLE.
- cont  input  1  continuous mode; sampled at end of each frame/gap.
- load  input  1  latch pat_in into the pattern register; honoured only in IDLE.
- pat_in  input  WIDTH  new pattern.
- j  output  1  serial data, registered.
- busy  output  1  high in SEND and GAP.
- done  output  1  one-cycle pulse coinciding with the last bit of each frame.
- frames  output  8  completed-frame count, saturating at 255.

Behaviour:
- Reset (rst==0 at an edge): state=IDLE; pat=PATTERN; j=IDLE_BIT; busy=0; done=0; frames=0; bit index=WIDTH-1; gap count=0. Reset mid-frame aborts immediately and takes precedence over every other input.
- All outputs are registered, with no combinational path from inputs to outputs.
- States: IDLE, SEND, GAP.
- IDLE:
  - load=1 latches pat_in into pat.
  - start=1 at edge k moves to SEND. In the cycle after edge k, j=bit WIDTH-1 and busy=1.
  - If load and start are both high at the same edge, the frame uses pat_in, not the old pat.
- SEND:
  - j carries pat[idx], and idx decrements each cycle.
  - In the cycle where idx==0 is on j, done=1.
  - At the edge ending the last bit, frames increments (saturating at 255), then the next state is chosen:
    - GAP>0 goes to GAP.
    - GAP==0 with cont=1 restarts SEND with idx=WIDTH-1, so frames run back-to-back with no idle bit.
    - GAP==0 with cont=0 goes to IDLE.
- GAP:
  - j=IDLE_BIT, busy=1, for exactly GAP cycles.
  - At the final gap edge, cont=1 goes to SEND; otherwise IDLE.
- Input handling while busy:
  - start is ignored in SEND and GAP, and is not queued.
  - load is ignored in SEND and GAP; pat is never modified during a frame.
  - Dropping cont mid-frame finishes the current frame (and its gap, if GAP>0), then returns to IDLE.
- Latency: start to first bit is 1 cycle. One frame occupies WIDTH cycles; the repeat period is WIDTH+GAP cycles.
- Widths: idx is ceil(log2(WIDTH)) bits; the gap counter is 4 bits. frames holds at 8'hFF with no wrap.

Decomposition:
- Shared package holds the state encoding localparams (IDLE=2'd0, SEND=2'd1, GAP=2'd2) and the default pattern constant (10010), so the detector benches reuse the same values.
- Single module; no sub-module is needed. Bit index and gap counter are inline down-counters.

Test Plan:
- Reset then single frame: defaults, start pulse at cycle 0.
  -> j=1,0,0,1,0 in cycles 1-5; done=1 only in cycle 5; busy=1 in cycles 1-7; j=0 and busy=0 from cycle 8; frames=1.
- Continuous, GAP=0 (override), cont held high.
  -> j=1001010010... with no gaps; a loopback mealy10010 flags each frame end, including overlap; frames counts 1,2,3 every 5 cycles.
- Load then start, pat_in=5'b11001, load and start at the same edge.
  -> j=1,1,0,0,1. A later load of 5'b00000 issued mid-frame is ignored, and the next frame repeats 11001.
- Start and load while busy: pulse start at cycle 3 of a frame.
  -> no restart and no extra frame; frames=1 after completion.
- Reset mid-frame: rst=0 at cycle 3.
  -> next cycle j=0, busy=0, done=0, frames=0, state IDLE. A subsequent start sends the full pattern 10010 again from bit 4.
- Saturation: cont=1 for 300 frames.
  -> frames reaches 255 and holds; done keeps pulsing every WIDTH+GAP cycles.

Source files
------------

// File: rtl/serial_pattern_tx_pkg.sv
// Shared encodings and defaults for the serial pattern transmitter
// and the sequence-detector benches that pair with it.
package serial_pattern_tx_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_SEND = ST_SEND,
        S_GAP  = ST_GAP
    } state_t;

    localparam int         DEF_WIDTH   = 5;
    localparam logic [4:0] DEF_PATTERN = 5'b10010;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Control and serial-output bundle of the pattern transmitter.
// master drives the controls; slave is the transmitter side.
interface serial_pattern_tx_if
    import serial_pattern_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             start;
    logic             cont;
    logic             load;
    logic [WIDTH-1:0] pat_in;
    logic             j;
    logic             busy;
    logic             done;
    logic [7:0]       frames;

    modport master (
        output start, cont, load, pat_in,
        input  j, busy, done, frames
    );

    modport slave (
        input  start, cont, load, pat_in,
        output j, busy, done, frames
    );

endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern MSB-first
// on j, as single frames or continuous repeats with optional gaps.
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] PATTERN  = WIDTH'(DEF_PATTERN),
    parameter int               GAP      = 2,
    parameter logic             IDLE_BIT = 1'b0
) (
    input logic              clk,
    input logic              rst,
    serial_pattern_tx_if.slave bus
);

    localparam int             IW      = $clog2(WIDTH);
    localparam logic [IW-1:0]  TOP     = IW'(WIDTH - 1);
    localparam logic [IW-1:0]  ONE     = IW'(1);
    localparam logic [3:0]     GAP_LEN = 4'(GAP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [3:0]       gcnt_q, gcnt_d;
    logic             j_q, j_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       frames_q, frames_d;

    // State and registered outputs; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pat_q    <= PATTERN;
            idx_q    <= TOP;
            gcnt_q   <= 4'd0;
            j_q      <= IDLE_BIT;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            frames_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            idx_q    <= idx_d;
            gcnt_q   <= gcnt_d;
            j_q      <= j_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            frames_q <= frames_d;
        end
    end

    // Next state and next output values, one bit shifted per cycle.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        idx_d    = idx_q;
        gcnt_d   = gcnt_q;
        j_d      = j_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        frames_d = frames_q;

        unique case (state_q)
            S_IDLE: begin
                j_d    = IDLE_BIT;
                busy_d = 1'b0;
                // A load coinciding with start feeds the new frame.
                if (bus.load) begin
                    pat_d = bus.pat_in;
                end
                if (bus.start) begin
                    state_d = S_SEND;
                    idx_d   = TOP;
                    j_d     = pat_d[TOP];
                    busy_d  = 1'b1;
                end
            end
            S_SEND: begin
                if (idx_q != '0) begin
                    idx_d  = idx_q - ONE;
                    j_d    = pat_q[idx_q - ONE];
                    done_d = (idx_q == ONE);
                end else begin
                    frames_d = sat_inc(frames_q);
                    idx_d    = TOP;
                    if (GAP_LEN != 4'd0) begin
                        state_d = S_GAP;
                        gcnt_d  = GAP_LEN;
                        j_d     = IDLE_BIT;
                    end else if (bus.cont) begin
                        j_d = pat_q[TOP];
                    end else begin
                        state_d = S_IDLE;
                        j_d     = IDLE_BIT;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_GAP: begin
                j_d = IDLE_BIT;
                if (gcnt_q > 4'd1) begin
                    gcnt_d = gcnt_q - 4'd1;
                end else begin
                    gcnt_d = 4'd0;
                    if (bus.cont) begin
                        state_d = S_SEND;
                        idx_d   = TOP;
                        j_d     = pat_q[TOP];
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                j_d     = IDLE_BIT;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.j      = j_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.frames = frames_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: one instance with GAP=2 and
// one with GAP=0 for back-to-back continuous frames.
module tb_serial_pattern_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    serial_pattern_tx_if #(.WIDTH(5)) a ();
    serial_pattern_tx_if #(.WIDTH(5)) b ();

    serial_pattern_tx #(
        .WIDTH(5), .PATTERN(5'b10010), .GAP(2), .IDLE_BIT(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(a)
    );

    serial_pattern_tx #(
        .WIDTH(5), .PATTERN(5'b10010), .GAP(0), .IDLE_BIT(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] p_def;
        logic [4:0] p_new;
        int         bi;
        int         fr;

        p_def = 5'b10010;
        p_new = 5'b11001;
        a.start = 0; a.cont = 0; a.load = 0; a.pat_in = '0;
        b.start = 0; b.cont = 0; b.load = 0; b.pat_in = '0;

        // Reset state
        rst = 0;
        tick();
        tick();
        chk("rst a.j", 32'(a.j), 0);
        chk("rst a.busy", 32'(a.busy), 0);
        chk("rst a.done", 32'(a.done), 0);
        chk("rst a.frames", 32'(a.frames), 0);
        chk("rst b.busy", 32'(b.busy), 0);
        chk("rst b.frames", 32'(b.frames), 0);
        rst = 1;
        tick();

        // Single frame with defaults
        a.start = 1;
        tick();
        a.start = 0;
        for (int c = 1; c <= 10; c++) begin
            bi = 5 - c;
            chk($sformatf("single j c%0d", c), 32'(a.j),
                (c <= 5) ? 32'(p_def[bi]) : 0);
            chk($sformatf("single busy c%0d", c), 32'(a.busy),
                (c <= 7) ? 1 : 0);
            chk($sformatf("single done c%0d", c), 32'(a.done),
                (c == 5) ? 1 : 0);
            chk($sformatf("single frames c%0d", c), 32'(a.frames),
                (c >= 6) ? 1 : 0);
            tick();
        end

        // Continuous back-to-back frames, GAP=0
        b.cont = 1;
        b.start = 1;
        tick();
        b.start = 0;
        for (int c = 1; c <= 21; c++) begin
            bi = 4 - ((c - 1) % 5);
            chk($sformatf("cont j c%0d", c), 32'(b.j),
                (c <= 20) ? 32'(p_def[bi]) : 0);
            chk($sformatf("cont done c%0d", c), 32'(b.done),
                (c <= 20 && c % 5 == 0) ? 1 : 0);
            chk($sformatf("cont busy c%0d", c), 32'(b.busy),
                (c <= 20) ? 1 : 0);
            chk($sformatf("cont frames c%0d", c), 32'(b.frames),
                32'((c - 1) / 5));
            if (c == 17) b.cont = 0;
            tick();
        end

        // Load and start together; mid-frame load ignored
        a.load = 1;
        a.pat_in = p_new;
        a.start = 1;
        tick();
        a.start = 0;
        a.load = 0;
        for (int c = 1; c <= 8; c++) begin
            bi = 5 - c;
            chk($sformatf("load j c%0d", c), 32'(a.j),
                (c <= 5) ? 32'(p_new[bi]) : 0);
            if (c == 2) begin
                a.load = 1;
                a.pat_in = 5'b00000;
            end else begin
                a.load = 0;
            end
            tick();
        end
        a.start = 1;
        tick();
        a.start = 0;
        for (int c = 1; c <= 8; c++) begin
            bi = 5 - c;
            chk($sformatf("reload j c%0d", c), 32'(a.j),
                (c <= 5) ? 32'(p_new[bi]) : 0);
            tick();
        end
        chk("reload frames", 32'(a.frames), 3);

        // Start and load while busy are ignored
        a.start = 1;
        tick();
        a.start = 0;
        for (int c = 1; c <= 12; c++) begin
            bi = 5 - c;
            chk($sformatf("busy j c%0d", c), 32'(a.j),
                (c <= 5) ? 32'(p_new[bi]) : 0);
            chk($sformatf("busy busy c%0d", c), 32'(a.busy),
                (c <= 7) ? 1 : 0);
            if (c == 3) begin
                a.start = 1;
                a.load = 1;
                a.pat_in = 5'b00000;
            end else begin
                a.start = 0;
                a.load = 0;
            end
            tick();
        end
        chk("busy frames", 32'(a.frames), 4);

        // Reset mid-frame
        a.start = 1;
        tick();
        a.start = 0;
        for (int c = 1; c <= 3; c++) begin
            bi = 5 - c;
            chk($sformatf("abort j c%0d", c), 32'(a.j), 32'(p_new[bi]));
            tick();
        end
        rst = 0;
        tick();
        chk("abort j", 32'(a.j), 0);
        chk("abort busy", 32'(a.busy), 0);
        chk("abort done", 32'(a.done), 0);
        chk("abort frames", 32'(a.frames), 0);
        rst = 1;
        a.start = 1;
        tick();
        a.start = 0;
        for (int c = 1; c <= 8; c++) begin
            bi = 5 - c;
            chk($sformatf("restart j c%0d", c), 32'(a.j),
                (c <= 5) ? 32'(p_def[bi]) : 0);
            tick();
        end
        chk("restart frames", 32'(a.frames), 1);

        // Saturation: 300 continuous frames with GAP=2
        a.cont = 1;
        a.start = 1;
        tick();
        a.start = 0;
        for (int c = 1; c <= 2100; c++) begin
            fr = 1 + (c + 1) / 7;
            if (fr > 255) fr = 255;
            chk($sformatf("sat done c%0d", c), 32'(a.done),
                (c % 7 == 5) ? 1 : 0);
            chk($sformatf("sat frames c%0d", c), 32'(a.frames), 32'(fr));
            if (c == 2100) a.cont = 0;
            tick();
        end
        chk("sat end busy", 32'(a.busy), 0);
        chk("sat end frames", 32'(a.frames), 255);
        chk("sat end j", 32'(a.j), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
